// File: rtl/multi_ch_accum_if.sv
`default_nettype none
// =============================================================================
// Module   : multi_ch_accum_if
// Brief    : Sample, clear and read-back signals of the multi-channel accumulator.
// Revision : 1.0
// =============================================================================
interface multi_ch_accum_if #(
    parameter int DATA_W = 12,
    parameter int ACC_W  = 32,
    parameter int N_CH   = 4,
    parameter int CH_W   = 2
);
    logic                     en;
    logic                     clr;
    logic [1:0]               mode;
    logic [CH_W-1:0]          ch;
    logic signed [DATA_W-1:0] x;
    logic [CH_W-1:0]          rd_ch;
    logic signed [ACC_W-1:0]  y;
    logic [N_CH-1:0]          sat;
    logic                     done;
    logic [CH_W-1:0]          done_ch;

    modport master (
        output en, clr, mode, ch, x, rd_ch,
        input  y, sat, done, done_ch
    );

    modport slave (
        input  en, clr, mode, ch, x, rd_ch,
        output y, sat, done, done_ch
    );
endinterface
`default_nettype wire

// File: rtl/multi_ch_accum.sv
`default_nettype none
// =============================================================================
// Module   : multi_ch_accum
// Brief    : N_CH saturating signed accumulators fed through a 2-stage pipe.
// Revision : 1.0
// =============================================================================
module multi_ch_accum #(
    parameter int DATA_W = 12,
    parameter int ACC_W  = 32,
    parameter int N_CH   = 4,
    parameter int CH_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    multi_ch_accum_if.slave    bus
);
    localparam logic [CH_W:0]      c_n_ch    = (CH_W+1)'(N_CH);
    localparam logic [ACC_W-1:0]   c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]   c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [1:0]         c_mode_peak = 2'd3;

    logic                      w_ch_ok;
    logic signed [DATA_W:0]    w_x_ext;
    logic signed [DATA_W:0]    w_abs;
    logic signed [2*DATA_W-1:0] w_sq;
    logic signed [ACC_W-1:0]   w_f;

    logic                      r_v1;
    logic [CH_W-1:0]           r_ch1;
    logic [1:0]                r_mode1;
    logic                      r_clr1;
    logic                      r_en1;
    logic signed [ACC_W-1:0]   r_f1;

    logic signed [ACC_W-1:0]   r_acc [N_CH];
    logic [N_CH-1:0]           r_sat;
    logic                      r_done;
    logic [CH_W-1:0]           r_done_ch;
    logic signed [ACC_W-1:0]   r_y;

    logic signed [ACC_W-1:0]   w_cur;
    logic [ACC_W:0]            w_sum;
    logic signed [ACC_W-1:0]   w_next;
    logic                      w_sat_set;
    logic                      w_sat_clr;
    logic signed [ACC_W-1:0]   w_rd;

    // Stage 1: transform; |x| uses one extra bit so the most negative x does not wrap
    assign w_ch_ok = ({1'b0, bus.ch} < c_n_ch);
    assign w_x_ext = {bus.x[DATA_W-1], bus.x};
    assign w_abs   = w_x_ext[DATA_W] ? -w_x_ext : w_x_ext;
    assign w_sq    = bus.x * bus.x;

    always_comb begin
        w_f = '0;
        case (bus.mode)
            2'd1:    w_f = {{(ACC_W-DATA_W){bus.x[DATA_W-1]}}, bus.x};
            2'd2:    w_f = {{(ACC_W-2*DATA_W){w_sq[2*DATA_W-1]}}, w_sq};
            default: w_f = {{(ACC_W-DATA_W-1){w_abs[DATA_W]}}, w_abs};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_ch1   <= '0;
            r_mode1 <= '0;
            r_clr1  <= 1'b0;
            r_en1   <= 1'b0;
            r_f1    <= '0;
        end else begin
            r_v1    <= (bus.en | bus.clr) & w_ch_ok;
            r_ch1   <= bus.ch;
            r_mode1 <= bus.mode;
            r_clr1  <= bus.clr;
            r_en1   <= bus.en;
            r_f1    <= w_f;
        end
    end

    // Stage 2: whole read-modify-write happens here, so back-to-back hits need no bypass
    always_comb begin
        w_cur = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (r_ch1 == CH_W'(i)) w_cur = r_acc[i];
        end
    end

    assign w_sum = {w_cur[ACC_W-1], w_cur} + {r_f1[ACC_W-1], r_f1};

    always_comb begin
        w_next    = w_cur;
        w_sat_set = 1'b0;
        w_sat_clr = 1'b0;
        if (r_clr1) begin
            w_next    = r_en1 ? r_f1 : '0;
            w_sat_clr = 1'b1;
        end else if (r_mode1 == c_mode_peak) begin
            w_next = (r_f1 > w_cur) ? r_f1 : w_cur;
        end else if (w_sum[ACC_W:ACC_W-1] == 2'b01) begin
            w_next    = c_acc_max;
            w_sat_set = 1'b1;
        end else if (w_sum[ACC_W:ACC_W-1] == 2'b10) begin
            w_next    = c_acc_min;
            w_sat_set = 1'b1;
        end else begin
            w_next = w_sum[ACC_W-1:0];
        end
    end

    // Out-of-range rd_ch matches no channel and reads back zero
    always_comb begin
        w_rd = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (bus.rd_ch == CH_W'(i)) w_rd = r_acc[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) r_acc[i] <= '0;
            r_sat     <= '0;
            r_done    <= 1'b0;
            r_done_ch <= '0;
            r_y       <= '0;
        end else begin
            r_done <= r_v1;
            if (r_v1) begin
                r_done_ch <= r_ch1;
                for (int i = 0; i < N_CH; i++) begin
                    if (r_ch1 == CH_W'(i)) begin
                        r_acc[i] <= w_next;
                        r_sat[i] <= ~w_sat_clr & (r_sat[i] | w_sat_set);
                    end
                end
            end
            r_y <= w_rd;
        end
    end

    assign bus.y       = r_y;
    assign bus.sat     = r_sat;
    assign bus.done    = r_done;
    assign bus.done_ch = r_done_ch;
endmodule
`default_nettype wire

// File: tb/tb_multi_ch_accum.sv
`default_nettype none
// =============================================================================
// Module   : tb_multi_ch_accum
// Brief    : Self-checking bench: default instance plus a narrow saturation instance.
// Revision : 1.0
// =============================================================================
module tb_multi_ch_accum;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multi_ch_accum_if #(.DATA_W(12), .ACC_W(32), .N_CH(4), .CH_W(2)) bus_a ();
    multi_ch_accum_if #(.DATA_W(8),  .ACC_W(16), .N_CH(3), .CH_W(2)) bus_b ();

    multi_ch_accum #(.DATA_W(12), .ACC_W(32), .N_CH(4), .CH_W(2)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );
    multi_ch_accum #(.DATA_W(8), .ACC_W(16), .N_CH(3), .CH_W(2)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int checks = 0;
    int errors = 0;
    int dones_a = 0;
    logic [1:0] qa[$];
    logic [1:0] qb[$];
    logic [1:0] ea, eb;

    typedef struct {
        bit         en;
        bit         clr;
        logic [1:0] mode;
        logic [1:0] ch;
        int         x;
        longint     exp_y;
        logic [3:0] exp_sat;
        string      name;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string n, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", n, act, exp);
        end
    endtask

    task automatic send_a(input bit e, input bit c, input logic [1:0] m, input logic [1:0] chn, input int xv);
        bus_a.en = e; bus_a.clr = c; bus_a.mode = m; bus_a.ch = chn; bus_a.x = 12'(xv);
        if (e | c) qa.push_back(chn);
        @(posedge clk); #1;
        bus_a.en = 1'b0; bus_a.clr = 1'b0;
    endtask

    task automatic send_b(input bit e, input bit c, input logic [1:0] m, input logic [1:0] chn, input int xv);
        bus_b.en = e; bus_b.clr = c; bus_b.mode = m; bus_b.ch = chn; bus_b.x = 8'(xv);
        if ((e | c) && chn < 2'd3) qb.push_back(chn);
        @(posedge clk); #1;
        bus_b.en = 1'b0; bus_b.clr = 1'b0;
    endtask

    task automatic read_a(input logic [1:0] c, input longint exp, input string n);
        bus_a.rd_ch = c;
        repeat (3) @(posedge clk);
        #1 chk(n, bus_a.y, exp);
    endtask

    task automatic read_b(input logic [1:0] c, input longint exp, input string n);
        bus_b.rd_ch = c;
        repeat (3) @(posedge clk);
        #1 chk(n, bus_b.y, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        qa.delete();
        qb.delete();
    endtask

    // Scoreboards: every commit must match the oldest channel pushed at drive time
    always @(negedge clk) begin
        if (bus_a.done === 1'b1) begin
            dones_a++;
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL done_a: unexpected done on ch %0d, expected none", bus_a.done_ch);
            end else begin
                ea = qa.pop_front();
                chk("done_ch_a", bus_a.done_ch, ea);
            end
        end
        if (bus_b.done === 1'b1) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL done_b: unexpected done on ch %0d, expected none", bus_b.done_ch);
            end else begin
                eb = qb.pop_front();
                chk("done_ch_b", bus_b.done_ch, eb);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        longint sum;
        int     xv;

        tbl[0]  = '{1'b0, 1'b1, 2'd0, 2'd0, 0,     64'sd0,       4'd0, "clr_ch0"};
        tbl[1]  = '{1'b1, 1'b0, 2'd0, 2'd1, -2048, 64'sd2048,    4'd0, "abs_min"};
        tbl[2]  = '{1'b1, 1'b0, 2'd2, 2'd1, -2048, 64'sd4196352, 4'd0, "sq_min"};
        tbl[3]  = '{1'b1, 1'b0, 2'd3, 2'd3, 5,     64'sd5,       4'd0, "peak_5"};
        tbl[4]  = '{1'b1, 1'b0, 2'd3, 2'd3, -9,    64'sd9,       4'd0, "peak_m9"};
        tbl[5]  = '{1'b1, 1'b0, 2'd3, 2'd3, 3,     64'sd9,       4'd0, "peak_3"};
        tbl[6]  = '{1'b1, 1'b0, 2'd1, 2'd2, -100,  -64'sd100,    4'd0, "signed_neg"};
        tbl[7]  = '{1'b1, 1'b0, 2'd3, 2'd2, -20,   64'sd20,      4'd0, "peak_over_neg"};
        tbl[8]  = '{1'b1, 1'b0, 2'd0, 2'd2, -100,  64'sd120,     4'd0, "abs_mix"};
        tbl[9]  = '{1'b1, 1'b1, 2'd0, 2'd1, -7,    64'sd7,       4'd0, "clr_load_abs"};
        tbl[10] = '{1'b1, 1'b1, 2'd2, 2'd3, -3,    64'sd9,       4'd0, "clr_load_sq"};
        tbl[11] = '{1'b1, 1'b0, 2'd2, 2'd0, 2047,  64'sd4190209, 4'd0, "sq_max"};
        tbl[12] = '{1'b1, 1'b0, 2'd1, 2'd0, -2048, 64'sd4188161, 4'd0, "signed_min"};

        bus_a.en = 1'b0; bus_a.clr = 1'b0; bus_a.mode = 2'd0; bus_a.ch = 2'd0; bus_a.x = '0; bus_a.rd_ch = 2'd0;
        bus_b.en = 1'b0; bus_b.clr = 1'b0; bus_b.mode = 2'd0; bus_b.ch = 2'd0; bus_b.x = '0; bus_b.rd_ch = 2'd0;
        do_reset();

        chk("rst_y_a", bus_a.y, 0);
        chk("rst_sat_a", bus_a.sat, 0);
        chk("rst_done_a", bus_a.done, 0);
        chk("rst_done_ch_a", bus_a.done_ch, 0);
        chk("rst_y_b", bus_b.y, 0);
        chk("rst_sat_b", bus_b.sat, 0);

        // Narrow instance: clamp in both directions, sticky flags, clear, invalid channel
        send_b(1'b1, 1'b0, 2'd2, 2'd0, -128);
        send_b(1'b1, 1'b0, 2'd2, 2'd0, -128);
        read_b(2'd0, 32767, "b_sat_pos_y");
        chk("b_sat_pos_flag", bus_b.sat, 3'b001);
        for (int i = 0; i < 300; i++) send_b(1'b1, 1'b0, 2'd1, 2'd2, -128);
        read_b(2'd2, -32768, "b_sat_neg_y");
        chk("b_sat_neg_flag", bus_b.sat, 3'b101);
        send_b(1'b0, 1'b1, 2'd0, 2'd0, 0);
        read_b(2'd0, 0, "b_clr_y");
        chk("b_clr_flag", bus_b.sat, 3'b100);
        send_b(1'b1, 1'b1, 2'd1, 2'd3, 5);
        read_b(2'd3, 0, "b_rd_invalid");
        read_b(2'd2, -32768, "b_invalid_keeps_ch2");
        chk("b_invalid_flag", bus_b.sat, 3'b100);
        send_b(1'b1, 1'b1, 2'd0, 2'd2, -7);
        read_b(2'd2, 7, "b_clr_load_y");
        chk("b_clr_load_flag", bus_b.sat, 3'b000);

        // Default instance: random |x| accumulation on ch0
        do_reset();
        dones_a = 0;
        sum = 0;
        for (int i = 0; i < 101; i++) begin
            xv = int'($urandom_range(4095, 0)) - 2048;
            sum += (xv < 0) ? -xv : xv;
            send_a(1'b1, 1'b0, 2'd0, 2'd0, xv);
        end
        read_a(2'd0, sum, "abs_sum");
        chk("abs_sat", bus_a.sat, 0);
        chk("abs_done_count", dones_a, 101);

        foreach (tbl[i]) begin
            send_a(tbl[i].en, tbl[i].clr, tbl[i].mode, tbl[i].ch, tbl[i].x);
            read_a(tbl[i].ch, tbl[i].exp_y, {tbl[i].name, "_y"});
            chk({tbl[i].name, "_sat"}, bus_a.sat, tbl[i].exp_sat);
        end

        // Latency: done two edges after en, y one edge after the commit
        do_reset();
        bus_a.rd_ch = 2'd1;
        bus_a.en = 1'b1; bus_a.mode = 2'd0; bus_a.ch = 2'd1; bus_a.x = -12'sd2048;
        qa.push_back(2'd1);
        @(posedge clk); #1 bus_a.en = 1'b0;
        chk("lat1_done_e1", bus_a.done, 0);
        @(posedge clk); #1;
        chk("lat1_done_e2", bus_a.done, 1);
        chk("lat1_y_old", bus_a.y, 0);
        @(posedge clk); #1;
        chk("lat1_done_e3", bus_a.done, 0);
        chk("lat1_y_new", bus_a.y, 2048);
        bus_a.en = 1'b1; bus_a.mode = 2'd2; bus_a.ch = 2'd1; bus_a.x = -12'sd2048;
        qa.push_back(2'd1);
        @(posedge clk); #1 bus_a.en = 1'b0;
        chk("lat2_done_e1", bus_a.done, 0);
        @(posedge clk); #1;
        chk("lat2_done_e2", bus_a.done, 1);
        chk("lat2_y_old", bus_a.y, 2048);
        @(posedge clk); #1;
        chk("lat2_y_e3", bus_a.y, 4196352);
        @(posedge clk); #1;
        chk("lat2_y_e4", bus_a.y, 4196352);

        // Back-to-back round robin across all channels
        do_reset();
        for (int i = 0; i < 8; i++) send_a(1'b1, 1'b0, 2'd1, 2'(i % 4), (i % 4) + 1);
        for (int c = 0; c < 4; c++) read_a(2'(c), 2 * (c + 1), $sformatf("b2b_ch%0d", c));

        // Reset one cycle after en: the in-flight sample must vanish without a done
        bus_a.en = 1'b1; bus_a.mode = 2'd1; bus_a.ch = 2'd0; bus_a.x = 12'sd100;
        @(posedge clk); #1 bus_a.en = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        dones_a = 0;
        read_a(2'd0, 0, "midrst_y0");
        read_a(2'd1, 0, "midrst_y1");
        chk("midrst_no_done", dones_a, 0);

        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
